// File: rtl/uart_script_player_pkg.sv
// rtl/uart_script_player_pkg.sv - shared FSM encoding and width helpers for the UART script player
package uart_script_player_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_STROBE,
        S_HOLD,
        S_WAIT_TX,
        S_GAP
    } tx_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // bits needed to hold 0..max_value, never less than one
    function automatic int width_for(input int max_value);
        int w;
        w = clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with registered head and flags
module uart_rx_fifo
    import uart_script_player_pkg::*;
#(
    parameter int depth = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] q,
    output logic       valid,
    output logic       full,
    output logic       empty
);

    localparam int AW = clog2(depth);
    localparam int CW = AW + 1;

    logic [7:0]    mem [depth];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(depth));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push && (!full || do_pop);
    assign count_n = count + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            q      <= '0;
            valid  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_n;
            valid <= (count_n != '0);
            // head register tracks the entry that will sit at rd_ptr after this edge
            if (do_pop && count > CW'(1)) begin
                q <= mem[AW'(rd_ptr + 1'b1)];
            end else if (do_push && (count == '0 || (do_pop && count == CW'(1)))) begin
                q <= din;
            end
        end
    end

endmodule

// File: rtl/uart_script_player.sv
// rtl/uart_script_player.sv - plays a loaded byte script into a UART and buffers received bytes
module uart_script_player
    import uart_script_player_pkg::*;
#(
    parameter int depth    = 16,
    parameter int gap      = 1000,
    parameter int rx_depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_we,
    input  logic [clog2(depth)-1:0]  load_adr,
    input  logic [7:0]               load_dat,
    input  logic [clog2(depth):0]    len,
    input  logic                     start,
    input  logic                     loop_en,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               tx_data,
    output logic                     tx_wr,
    input  logic                     tx_busy,
    input  logic [7:0]               rx_data,
    input  logic                     rx_avail,
    output logic                     rx_ack,
    output logic [7:0]               rx_q,
    output logic                     rx_valid,
    input  logic                     rx_pop,
    output logic                     rx_overflow
);

    localparam int AW = clog2(depth);
    localparam int GW = width_for(gap);

    tx_state_e     state;
    tx_state_e     state_n;
    logic [7:0]    script [depth];
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_n;
    logic [AW:0]   len_q;
    logic          loop_q;
    logic          abort_q;
    logic          abort_now;
    logic [GW-1:0] gap_cnt;
    logic          gap_last;
    logic          done_n;
    logic          play_start;
    logic          rx_take;
    logic [7:0]    rx_hold;
    logic          fifo_full;
    logic          fifo_empty;

    assign play_start = (state == S_IDLE) && start && (len != '0);
    assign abort_now  = abort_q || abort;
    assign gap_last   = (gap == 0) || (gap_cnt == GW'(gap - 1));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = S_WAIT_RDY;
                        idx_n   = '0;
                    end
                end
            end
            S_WAIT_RDY: if (!tx_busy) state_n = S_STROBE;
            S_STROBE:   state_n = S_HOLD;
            S_HOLD:     state_n = S_WAIT_TX;
            S_WAIT_TX:  if (!tx_busy) state_n = S_GAP;
            S_GAP: begin
                if (gap_last) begin
                    if (abort_now) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else if (({1'b0, idx} + 1'b1) < len_q) begin
                        idx_n   = idx + 1'b1;
                        state_n = S_WAIT_RDY;
                    end else if (loop_q) begin
                        idx_n   = '0;
                        state_n = S_WAIT_RDY;
                    end else begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            abort_q <= 1'b0;
            gap_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tx_wr   <= 1'b0;
            tx_data <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            busy    <= (state_n != S_IDLE);
            done    <= done_n;
            tx_wr   <= (state_n == S_STROBE);
            if (state_n == S_STROBE) tx_data <= script[idx_n];
            if (play_start) begin
                len_q  <= len;
                loop_q <= loop_en;
            end
            abort_q <= (state_n == S_IDLE) ? 1'b0 : (abort_q || (state != S_IDLE && abort));
            gap_cnt <= (state == S_GAP && state_n == S_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    // script edits are only honoured between playbacks
    always_ff @(posedge clk) begin
        if (load_we && state == S_IDLE) script[load_adr] <= load_dat;
    end

    assign rx_take = rx_avail && !rx_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ack      <= 1'b0;
            rx_hold     <= '0;
            rx_overflow <= 1'b0;
        end else begin
            rx_ack <= rx_take;
            if (rx_take) rx_hold <= rx_data;
            if (rx_ack && fifo_full && !(rx_pop && !fifo_empty)) begin
                rx_overflow <= 1'b1;
            end else if (play_start) begin
                rx_overflow <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .depth(rx_depth)
    ) u_rx_fifo (
        .clk  (clk),
        .reset(reset),
        .push (rx_ack),
        .din  (rx_hold),
        .pop  (rx_pop),
        .q    (rx_q),
        .valid(rx_valid),
        .full (fifo_full),
        .empty(fifo_empty)
    );

endmodule

// File: tb/tb_uart_script_player.sv
// tb/tb_uart_script_player.sv - randomized bench with a behavioural playback/FIFO model
module tb_uart_script_player;

    localparam int DEPTH = 16;
    localparam int GAP   = 10;
    localparam int RXD   = 8;
    localparam int FRAME = 20;
    localparam int P     = FRAME + GAP + 3;

    logic       clk;
    logic       reset;
    logic       load_we;
    logic [3:0] load_adr;
    logic [7:0] load_dat;
    logic [4:0] len;
    logic       start;
    logic       loop_en;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_ack;
    logic [7:0] rx_q;
    logic       rx_valid;
    logic       rx_pop;
    logic       rx_overflow;

    uart_script_player #(
        .depth(DEPTH), .gap(GAP), .rx_depth(RXD)
    ) dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_adr(load_adr),
        .load_dat(load_dat), .len(len), .start(start), .loop_en(loop_en),
        .abort(abort), .busy(busy), .done(done), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
        .rx_q(rx_q), .rx_valid(rx_valid), .rx_pop(rx_pop), .rx_overflow(rx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // behavioural model state
    int         cyc = 0;
    bit         active = 0;
    int         n0, nstr, plen;
    bit         ploop;
    logic [7:0] smodel [DEPTH];
    logic [7:0] q_m [$];
    bit         ovf_m = 0, staged = 0, ack_prev = 0;
    logic [7:0] staged_b;
    int         ack_cnt = 0, done_cnt = 0;
    logic [7:0] tx_log [$];
    int         tx_t [$];

    // stimulus-side state
    logic [7:0] rx_todo [$];
    int         pop_mode = 0;

    initial begin
        longint done_rel, rel;
        bit     was, exp_wr;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                active = 0; q_m.delete(); ovf_m = 0; staged = 0; ack_prev = 0;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_tx_wr", tx_wr, 0);
                chk("rst_tx_data", tx_data, 0);
                chk("rst_rx_ack", rx_ack, 0);
                chk("rst_rx_valid", rx_valid, 0);
                chk("rst_rx_q", rx_q, 0);
                chk("rst_rx_overflow", rx_overflow, 0);
            end else begin
                was = active;
                if (load_we && !was) smodel[load_adr] = load_dat;
                if (start && !was) begin
                    n0 = cyc; plen = int'(len); ploop = loop_en; active = 1;
                    nstr = (plen == 0) ? 0 : (ploop ? (1 << 30) : plen);
                    if (plen != 0) ovf_m = 0;
                end
                if (abort && was) begin
                    // playback ends at the first end-of-byte point at or after the abort
                    int j = 0;
                    while (n0 + (j + 1) * P < cyc) j++;
                    if (j + 1 < nstr) nstr = j + 1;
                end
                if (active) begin
                    rel      = longint'(cyc - n0);
                    done_rel = (nstr == 0) ? 0 : 1 + longint'(nstr - 1) * P + FRAME + GAP + 2;
                    exp_wr   = (rel >= 1) && ((rel - 1) % P == 0) && ((rel - 1) / P < nstr);
                    chk("tx_wr", tx_wr, exp_wr);
                    if (exp_wr) chk("tx_data", tx_data, smodel[((rel - 1) / P) % plen]);
                    chk("done", done, rel == done_rel);
                    chk("busy", busy, rel < done_rel);
                    if (rel == done_rel) active = 0;
                end else begin
                    chk("idle_tx_wr", tx_wr, 0);
                    chk("idle_done", done, 0);
                    chk("idle_busy", busy, 0);
                end
                if (rx_pop && q_m.size() != 0) void'(q_m.pop_front());
                if (staged) begin
                    if (q_m.size() < RXD) q_m.push_back(staged_b);
                    else ovf_m = 1;
                    staged = 0;
                end
                staged   = rx_avail && !ack_prev;
                staged_b = rx_data;
                ack_prev = staged;
                chk("rx_ack", rx_ack, staged);
                chk("rx_valid", rx_valid, q_m.size() != 0);
                if (q_m.size() != 0) chk("rx_q", rx_q, q_m[0]);
                chk("rx_overflow", rx_overflow, ovf_m);
            end
            if (tx_wr) begin
                tx_log.push_back(tx_data);
                tx_t.push_back(cyc);
            end
            if (done) done_cnt++;
            if (rx_ack) ack_cnt++;
        end
    end

    // partner UART transmitter: busy for FRAME+1 edges after each strobe
    initial begin
        int cnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) cnt = 0;
            else if (tx_wr) cnt = FRAME + 1;
            else if (cnt > 0) cnt--;
            tx_busy = (cnt > 0);
        end
    end

    // partner UART receiver: presents queued bytes and clears avail once acked
    initial begin
        int wait_cnt = 0;
        rx_avail = 1'b0;
        rx_data  = '0;
        forever begin
            @(negedge clk);
            if (rx_ack) begin
                rx_avail = 1'b0;
            end else if (!rx_avail && rx_todo.size() != 0 && wait_cnt == 0) begin
                rx_data  = rx_todo.pop_front();
                rx_avail = 1'b1;
                wait_cnt = $urandom_range(0, 3);
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
        end
    end

    initial begin
        rx_pop = 1'b0;
        forever begin
            @(negedge clk);
            case (pop_mode)
                1:       rx_pop = 1'($urandom_range(0, 1));
                2:       rx_pop = rx_ack;
                default: rx_pop = 1'b0;
            endcase
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic load(input int adr, input logic [7:0] dat);
        load_we = 1'b1; load_adr = 4'(adr); load_dat = dat;
        tick();
        load_we = 1'b0;
    endtask

    task automatic play(input int l, input bit lp);
        start = 1'b1; len = 5'(l); loop_en = lp;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (active && k < budget) begin tick(); k++; end
        checks++;
        if (active) begin
            errors++;
            $display("FAIL wait_idle: got busy expected idle within %0d cycles", budget);
        end
    endtask

    task automatic wait_strobes(input int total, input int budget);
        int k = 0;
        while (tx_log.size() < total && k < budget) begin tick(); k++; end
        checks++;
        if (tx_log.size() < total) begin
            errors++;
            $display("FAIL wait_strobes: got %0d expected %0d", tx_log.size(), total);
        end
    endtask

    task automatic wait_rx(input int budget);
        int k = 0;
        while ((rx_todo.size() != 0 || rx_avail || staged) && k < budget) begin tick(); k++; end
        tick(3);
        checks++;
        if (rx_todo.size() != 0 || rx_avail) begin
            errors++;
            $display("FAIL wait_rx: got %0d pending expected 0", rx_todo.size());
        end
    endtask

    task automatic drain();
        int k = 0;
        pop_mode = 1;
        while ((q_m.size() != 0 || staged) && k < 500) begin tick(); k++; end
        pop_mode = 0;
        tick(2);
        chk("drain_empty", rx_valid, 0);
    endtask

    initial begin
        int         bl, bd, ba, l;
        logic [7:0] v [4];
        reset = 1'b1; load_we = 0; load_adr = 0; load_dat = 0; len = 0;
        start = 0; loop_en = 0; abort = 0;
        tick(4);
        reset = 1'b0;
        tick();
        chk("reset_tx_data", tx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);

        abort = 1'b1; tick(); abort = 1'b0;

        load(0, 8'h67); load(1, 8'h00); load(2, 8'h00);
        bl = tx_log.size(); bd = done_cnt;
        play(3, 0);
        wait_idle(5 * P);
        chk("t1_count", tx_log.size() - bl, 3);
        if (tx_log.size() - bl == 3) begin
            chk("t1_b0", tx_log[bl], 8'h67);
            chk("t1_b1", tx_log[bl + 1], 8'h00);
            chk("t1_b2", tx_log[bl + 2], 8'h00);
            chk("t1_period01", tx_t[bl + 1] - tx_t[bl], 33);
            chk("t1_period12", tx_t[bl + 2] - tx_t[bl + 1], 33);
        end
        chk("t1_done", done_cnt - bd, 1);

        bl = tx_log.size(); bd = done_cnt;
        play(0, 0);
        tick(3);
        chk("t2_no_tx", tx_log.size() - bl, 0);
        chk("t2_done", done_cnt - bd, 1);

        load(0, 8'hA5); load(1, 8'h5A);
        bl = tx_log.size(); bd = done_cnt;
        play(2, 1);
        wait_strobes(bl + 3, 4 * P);
        tick($urandom_range(1, FRAME));
        abort = 1'b1; tick(); abort = 1'b0;
        wait_idle(3 * P);
        tick(P);
        chk("t3_count", tx_log.size() - bl, 3);
        if (tx_log.size() - bl == 3) begin
            chk("t3_b0", tx_log[bl], 8'hA5);
            chk("t3_b1", tx_log[bl + 1], 8'h5A);
            chk("t3_b2", tx_log[bl + 2], 8'hA5);
        end
        chk("t3_done", done_cnt - bd, 1);

        pop_mode = 1;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) load(a, 8'($urandom));
            for (int b = 0; b < 6; b++) rx_todo.push_back(8'($urandom));
            l = $urandom_range(0, DEPTH);
            play(l, 0);
            if (it == 2) begin
                tick(5);
                start = 1'b1; len = 5'd1; tick(); start = 1'b0;
                load(0, 8'hFF);
            end
            wait_idle(l * P + 4 * P);
        end
        wait_rx(400);
        drain();

        play(1, 0);
        wait_idle(3 * P);
        for (int b = 0; b < 8; b++) rx_todo.push_back(8'(8'h10 + b));
        wait_rx(200);
        pop_mode = 2;
        rx_todo.push_back(8'h18);
        wait_rx(50);
        pop_mode = 0;
        tick(2);
        chk("pp_head", rx_q, 8'h11);
        chk("pp_overflow", rx_overflow, 0);
        chk("pp_valid", rx_valid, 1);
        drain();

        ba = ack_cnt;
        for (int b = 0; b < 10; b++) rx_todo.push_back(8'(8'h20 + b));
        wait_rx(300);
        chk("ov_flag", rx_overflow, 1);
        chk("ov_acks", ack_cnt - ba, 10);
        chk("ov_head", rx_q, 8'h20);
        drain();

        for (int a = 0; a < 4; a++) begin
            v[a] = 8'($urandom);
            load(a, v[a]);
        end
        bl = tx_log.size(); bd = done_cnt;
        play(4, 0);
        wait_strobes(bl + 2, 3 * P);
        tick(FRAME + 5);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rm_busy", busy, 0);
        chk("rm_tx_wr", tx_wr, 0);
        chk("rm_done", done, 0);
        tick(3 * P);
        chk("rm_no_more_tx", tx_log.size() - bl, 2);
        chk("rm_no_done", done_cnt - bd, 0);
        bl = tx_log.size();
        play(4, 0);
        wait_idle(6 * P);
        chk("rm_replay_count", tx_log.size() - bl, 4);
        if (tx_log.size() - bl == 4) begin
            for (int a = 0; a < 4; a++) chk("rm_replay_byte", tx_log[bl + a], v[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
